bcd_xs3_word_seq: RTL and testbench



---
 rtl/bcd_xs3_pkg.sv | 15 +
 rtl/bcd_xs3_digit.sv | 17 +
 rtl/bcd_xs3_word_seq.sv | 99 +++++++++
 tb/tb_bcd_xs3_word_seq.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_xs3_pkg.sv
// Shared types and constants for the BCD to Excess-3 word converter.
// Used by the digit converter and the word sequencer.
package bcd_xs3_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [3:0] XS3_OFFSET  = 4'd3;
  localparam logic [3:0] BCD_MAX     = 4'd9;
  localparam logic [3:0] XS3_INVALID = 4'h0;

endpackage

// File: rtl/bcd_xs3_digit.sv
// Combinational single-digit BCD to Excess-3 converter.
// Non-BCD codes map to XS3_INVALID and raise invalid.
module bcd_xs3_digit
  import bcd_xs3_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [3:0] xs3,
  output logic       invalid
);

  // Range check first, then offset the legal codes.
  always_comb begin
    invalid = (bcd > BCD_MAX);
    xs3     = invalid ? XS3_INVALID : bcd + XS3_OFFSET;
  end

endmodule

// File: rtl/bcd_xs3_word_seq.sv
// Multi-digit BCD to Excess-3 word converter, one digit per cycle,
// LSD first, through a single shared digit converter.
module bcd_xs3_word_seq
  import bcd_xs3_pkg::*;
#(
  parameter int NDIGITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NDIGITS-1:0] in_bcd,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NDIGITS-1:0] out_xs3,
  output logic                 out_err
);

  localparam int W  = 4 * NDIGITS;
  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NDIGITS - 1);

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  in_q, in_d;
  logic [W-1:0]  res_q, res_d;
  logic          err_q, err_d;

  logic [3:0] dig_bcd;
  logic [3:0] dig_xs3;
  logic       dig_inv;

  assign dig_bcd = in_q[4*int'(idx_q) +: 4];

  bcd_xs3_digit u_digit (
    .bcd     (dig_bcd),
    .xs3     (dig_xs3),
    .invalid (dig_inv)
  );

  // Handshake flags depend on state only, never on in_valid/out_ready.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_xs3   = res_q;
  assign out_err   = err_q;

  // Next-state, digit index and datapath updates.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    in_d    = in_q;
    res_d   = res_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          in_d    = in_bcd;
          res_d   = '0;
          err_d   = 1'b0;
          idx_d   = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        res_d[4*int'(idx_q) +: 4] = dig_xs3;
        err_d = err_q | dig_inv;
        if (idx_q == LAST) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any word in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      in_q    <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      in_q    <= in_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_bcd_xs3_word_seq.sv
// Directed scoreboard bench for bcd_xs3_word_seq with NDIGITS=4.
// Expected words are modelled at accept time and checked at output.
module tb_bcd_xs3_word_seq;

  typedef struct packed {
    logic [15:0] xs3;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_bcd;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_xs3;
  logic        out_err;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   acc_cyc  = 0;
  int   acc_a;
  exp_t sb[$];

  bcd_xs3_word_seq #(.NDIGITS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bcd    (in_bcd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_xs3   (out_xs3),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [15:0] w);
    exp_t e;
    logic [3:0] d;
    e.xs3 = '0;
    e.err = 1'b0;
    for (int k = 0; k < 4; k++) begin
      d = w[4*k +: 4];
      if (d > 4'd9) begin
        e.err = 1'b1;
      end else begin
        e.xs3[4*k +: 4] = d + 4'd3;
      end
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; drives the word and returns at the negedge
  // after the accept edge.
  task automatic send(input logic [15:0] w, input bit keep,
                      input bit push);
    int n = 0;
    in_valid = 1'b1;
    in_bcd   = w;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'(in_ready), 32'd1);
    end else begin
      if (push) sb.push_back(model(w));
      @(posedge clk);
      @(negedge clk);
      acc_cyc = cyc;
      if (!keep) in_valid = 1'b0;
    end
  endtask

  task automatic recv(input string tag);
    int   n = 0;
    exp_t e;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      chk({tag, "_timeout"}, 32'(out_valid), 32'd1);
    end else if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_xs3"}, 32'(out_xs3), 32'(e.xs3));
      chk({tag, "_err"}, 32'(out_err), 32'(e.err));
      chk({tag, "_lat"}, 32'(cyc - acc_cyc), 32'd4);
      if (out_ready) begin
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_vld_drop"}, 32'(out_valid), 32'd0);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_bcd    = '0;
    out_ready = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_xs3", 32'(out_xs3), 32'h0000);
    chk("rst_out_err", 32'(out_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Basic conversion
    out_ready = 1'b1;
    send(16'h1234, 1'b0, 1'b1);
    chk("basic_model", 32'(sb[0].xs3), 32'h4567);
    recv("basic");

    // Invalid digit, then err cleared by the next word
    send(16'h9A05, 1'b0, 1'b1);
    recv("inv");
    send(16'h0000, 1'b0, 1'b1);
    recv("zero");

    // Backpressure
    out_ready = 1'b0;
    send(16'h5678, 1'b0, 1'b1);
    in_valid = 1'b1;
    in_bcd   = 16'h1111;
    recv("bp");
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_xs3", 32'(out_xs3), 32'h89AB);
      chk("bp_hold_vld", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_release_rdy", 32'(in_ready), 32'd1);
    send(16'h1111, 1'b0, 1'b1);
    recv("bp_next");

    // Reset in the middle of conversion
    send(16'h4321, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_xs3", 32'(out_xs3), 32'h0000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(16'h0987, 1'b0, 1'b1);
    recv("after_rst");

    // Back-to-back with in_valid held high
    send(16'h9999, 1'b1, 1'b1);
    acc_a  = acc_cyc;
    in_bcd = 16'h0000;
    recv("b2b_a");
    send(16'h0000, 1'b0, 1'b1);
    chk("b2b_gap", 32'(acc_cyc - acc_a), 32'd6);
    recv("b2b_b");

    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
